// File: rtl/demultiplexor_buf_if.sv
// Handshake bundle for demultiplexor_buf: one input stream and four buffered output lanes.
// The slave modport is the demultiplexer side and the master modport is the source/consumer side.
interface demultiplexor_buf_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   i_data;
    logic [1:0]         i_sel;
    logic               i_valid;
    logic               o_ready;
    logic [4*WIDTH-1:0] o_data;
    logic [3:0]         o_valid;
    logic [3:0]         i_ready;
    logic [15:0]        o_accept_cnt;

    modport slave (
        input  i_data,
        input  i_sel,
        input  i_valid,
        input  i_ready,
        output o_ready,
        output o_data,
        output o_valid,
        output o_accept_cnt
    );

    modport master (
        output i_data,
        output i_sel,
        output i_valid,
        output i_ready,
        input  o_ready,
        input  o_data,
        input  o_valid,
        input  o_accept_cnt
    );
endinterface

// File: rtl/demultiplexor_buf.sv
// Registered 1-to-4 demultiplexer with a single-entry buffer per lane and an accept counter.
// A stalled lane only blocks words addressed to it; other lanes keep flowing.
module demultiplexor_buf #(
    parameter int WIDTH = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    demultiplexor_buf_if.slave  bus
);

    logic [3:0][WIDTH-1:0] data_q;
    logic [3:0][WIDTH-1:0] data_d;
    logic [3:0]            valid_q;
    logic [3:0]            valid_d;
    logic [15:0]           cnt_q;
    logic [15:0]           cnt_d;

    logic                  ready_s;
    logic                  in_xfer_s;
    logic [3:0]            load_s;

    // Only the addressed lane decides acceptance; this path is combinational by design.
    assign ready_s   = !valid_q[bus.i_sel] || bus.i_ready[bus.i_sel];
    assign in_xfer_s = bus.i_valid && ready_s;

    // Decode which lane (if any) loads the incoming word this cycle.
    always_comb begin
        load_s = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            if (in_xfer_s && (bus.i_sel == 2'(n))) begin
                load_s[n] = 1'b1;
            end else begin
                load_s[n] = 1'b0;
            end
        end
    end

    // Per-lane EMPTY/FULL next state; a simultaneous load and drain keeps the lane full.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int n = 0; n < 4; n++) begin
            if (load_s[n]) begin
                valid_d[n] = 1'b1;
                data_d[n]  = bus.i_data;
            end else if (valid_q[n] && bus.i_ready[n]) begin
                valid_d[n] = 1'b0;
            end else begin
                valid_d[n] = valid_q[n];
            end
        end
    end

    // Free-running accept counter, wraps naturally at 16 bits.
    always_comb begin
        if (in_xfer_s) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset discards every buffered word immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 4'b0000;
            data_q  <= '0;
            cnt_q   <= 16'd0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_ready      = ready_s;
    assign bus.o_valid      = valid_q;
    assign bus.o_data       = data_q;
    assign bus.o_accept_cnt = cnt_q;

endmodule

// File: tb/tb_demultiplexor_buf.sv
// Directed bench for demultiplexor_buf: queue-based lane model checked every cycle,
// plus literal expectations and a log of words the DUT actually delivered per lane.
module tb_demultiplexor_buf;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   dut_acc;

    demultiplexor_buf_if #(.WIDTH(8)) bus ();

    demultiplexor_buf #(.WIDTH(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mq[4][$];
    logic [15:0] m_cnt;
    logic [7:0]  dg[4][$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lane(input int n);
        return bus.o_data[n*8 +: 8];
    endfunction

    function automatic bit model_ready();
        return (mq[bus.i_sel].size() == 0) || (bus.i_ready[bus.i_sel] == 1'b1);
    endfunction

    task automatic model_pop();
        for (int n = 0; n < 4; n++) begin
            if (mq[n].size() != 0 && bus.i_ready[n]) void'(mq[n].pop_front());
        end
    endtask

    // Reference model: each lane is a queue holding at most one word.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 4; n++) mq[n].delete();
            m_cnt <= 16'd0;
        end else if (bus.i_valid && model_ready()) begin
            model_pop();
            mq[bus.i_sel].push_back(bus.i_data);
            m_cnt <= m_cnt + 16'd1;
        end else begin
            model_pop();
        end
    end

    // Log what the DUT really hands to consumers and how many words it accepted.
    always @(posedge clk) begin
        if (rst_n) begin
            for (int n = 0; n < 4; n++) begin
                if (bus.o_valid[n] && bus.i_ready[n]) dg[n].push_back(lane(n));
            end
            if (bus.i_valid && bus.o_ready) dut_acc <= dut_acc + 1;
        end
    end

    // Compare DUT outputs with the model on every falling edge out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int n = 0; n < 4; n++) begin
                chk($sformatf("model_valid%0d", n), {31'd0, bus.o_valid[n]},
                    (mq[n].size() != 0) ? 32'd1 : 32'd0);
                if (mq[n].size() != 0) chk($sformatf("model_data%0d", n), {24'd0, lane(n)}, {24'd0, mq[n][0]});
            end
            chk("model_cnt", {16'd0, bus.o_accept_cnt}, {16'd0, m_cnt});
            chk("model_ready", {31'd0, bus.o_ready}, model_ready() ? 32'd1 : 32'd0);
        end
    end

    task automatic setin(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
        bus.i_valid = v;
        bus.i_sel   = s;
        bus.i_data  = d;
        bus.i_ready = r;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic cyc(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
        setin(v, s, d, r);
        step();
    endtask

    task automatic clear_logs();
        for (int n = 0; n < 4; n++) dg[n].delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc0;
        checks  = 0;
        errors  = 0;
        dut_acc = 0;
        rst_n   = 1'b0;
        setin(1'b0, 2'd2, 8'h00, 4'b0000);
        step();
        chk("rst_valid", {28'd0, bus.o_valid}, 32'd0);
        chk("rst_data", bus.o_data, 32'd0);
        chk("rst_cnt", {16'd0, bus.o_accept_cnt}, 32'd0);
        chk("rst_ready", {31'd0, bus.o_ready}, 32'd1);
        rst_n = 1'b1;

        // 0xA1 to lane 2 with every consumer stalled
        cyc(1'b1, 2'd2, 8'hA1, 4'b0000);
        chk("a1_valid", {28'd0, bus.o_valid}, 32'h4);
        chk("a1_data", {24'd0, lane(2)}, 32'hA1);
        chk("a1_cnt", {16'd0, bus.o_accept_cnt}, 32'd1);
        setin(1'b0, 2'd0, 8'h00, 4'b0000);
        #1 chk("a1_ready_sel0", {31'd0, bus.o_ready}, 32'd1);
        bus.i_sel = 2'd2;
        #1 chk("a1_ready_sel2", {31'd0, bus.o_ready}, 32'd0);
        step();
        cyc(1'b0, 2'd0, 8'h00, 4'b0100);

        // Same-cycle drain and reload on lane 1
        cyc(1'b1, 2'd1, 8'h11, 4'b0000);
        setin(1'b1, 2'd1, 8'h22, 4'b0010);
        #1 chk("reload_ready", {31'd0, bus.o_ready}, 32'd1);
        step();
        chk("reload_data", {24'd0, lane(1)}, 32'h22);
        chk("reload_valid", {31'd0, bus.o_valid[1]}, 32'd1);
        cyc(1'b0, 2'd0, 8'h00, 4'b0010);
        chk("reload_log_n", dg[1].size(), 32'd2);
        if (dg[1].size() == 2) begin
            chk("reload_log0", {24'd0, dg[1][0]}, 32'h11);
            chk("reload_log1", {24'd0, dg[1][1]}, 32'h22);
        end
        chk("a1_log_n", dg[2].size(), 32'd1);
        if (dg[2].size() == 1) chk("a1_log0", {24'd0, dg[2][0]}, 32'hA1);
        clear_logs();

        // Backpressure on lane 3 must not block lane 0
        cyc(1'b1, 2'd3, 8'h33, 4'b0000);
        setin(1'b1, 2'd3, 8'h30, 4'b0000);
        #1 chk("bp_ready3", {31'd0, bus.o_ready}, 32'd0);
        step();
        chk("bp_hold3", {24'd0, lane(3)}, 32'h33);
        setin(1'b1, 2'd0, 8'h40, 4'b0000);
        #1 chk("bp_ready0", {31'd0, bus.o_ready}, 32'd1);
        step();
        chk("bp_lane0", {24'd0, lane(0)}, 32'h40);
        chk("bp_valid", {28'd0, bus.o_valid}, 32'h9);
        setin(1'b1, 2'd3, 8'h30, 4'b1000);
        #1 chk("bp_release", {31'd0, bus.o_ready}, 32'd1);
        step();
        chk("bp_lane3", {24'd0, lane(3)}, 32'h30);
        cyc(1'b0, 2'd0, 8'h00, 4'b1111);
        chk("bp_log3_n", dg[3].size(), 32'd2);
        if (dg[3].size() == 2) begin
            chk("bp_log3_0", {24'd0, dg[3][0]}, 32'h33);
            chk("bp_log3_1", {24'd0, dg[3][1]}, 32'h30);
        end

        // Asynchronous reset with lanes 0 and 2 full
        cyc(1'b1, 2'd0, 8'h55, 4'b0000);
        cyc(1'b1, 2'd2, 8'h66, 4'b0000);
        chk("mid_full", {28'd0, bus.o_valid}, 32'h5);
        setin(1'b0, 2'd0, 8'h00, 4'b0000);
        rst_n = 1'b0;
        #1;
        chk("mid_valid", {28'd0, bus.o_valid}, 32'd0);
        chk("mid_data", bus.o_data, 32'd0);
        chk("mid_cnt", {16'd0, bus.o_accept_cnt}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("mid_after", {28'd0, bus.o_valid}, 32'd0);
        clear_logs();

        // Round-robin streaming with every consumer ready
        acc0 = dut_acc;
        for (int i = 0; i < 16; i++) begin
            setin(1'b1, 2'(i % 4), 8'(i), 4'b1111);
            #1 chk("stream_ready", {31'd0, bus.o_ready}, 32'd1);
            step();
        end
        cyc(1'b0, 2'd0, 8'h00, 4'b1111);
        chk("stream_cnt", {16'd0, bus.o_accept_cnt}, 32'd16);
        chk("stream_acc", dut_acc - acc0, 32'd16);
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("stream_log%0d_n", n), dg[n].size(), 32'd4);
            if (dg[n].size() == 4) begin
                for (int k = 0; k < 4; k++)
                    chk($sformatf("stream_log%0d_%0d", n, k), {24'd0, dg[n][k]}, 32'(n + 4 * k));
            end
        end

        // Counter wrap after 65537 accepts
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 65537; i++) cyc(1'b1, 2'd0, 8'(i), 4'b0001);
        setin(1'b0, 2'd0, 8'h00, 4'b0001);
        chk("wrap_cnt", {16'd0, bus.o_accept_cnt}, 32'h1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demultiplexor_buf.md
# demultiplexor_buf

Registered 1-to-4 demultiplexer: the routing counterpart of the 4:1 `Multiplexor`, steering one input stream to one of four output lanes. Each accepted word goes to the lane named by `i_sel`. It is held in a single-entry buffer per lane until that lane's consumer takes it. Valid/ready handshakes on both sides provide backpressure, and a free-running accept counter supports debug.

## Interface
Parameters:
- `WIDTH`, default 8: data width per word and per output lane.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_data`  in  WIDTH  input word.
- `i_sel`  in  2  destination lane, 0..3; sampled with `i_data`.
- `i_valid`  in  1  input word and `i_sel` are valid.
- `o_ready`  out  1  block can accept the input this cycle.
- `o_data`  out  4*WIDTH  lane n occupies bits [n*WIDTH +: WIDTH].
- `o_valid`  out  4  per-lane buffer holds a word.
- `i_ready`  in  4  per-lane consumer accepts the word this cycle.
- `o_accept_cnt`  out  16  number of input words accepted since reset.

## Operation
- Input transfer occurs when `i_valid && o_ready`.
- Output transfer on lane n occurs when `o_valid[n] && i_ready[n]`.
- Each lane has two states, EMPTY (`o_valid[n]=0`) and FULL (`o_valid[n]=1`). Transitions:
  - EMPTY to FULL: input transfer with `i_sel==n`.
  - FULL to EMPTY: output transfer on lane n with no input transfer to n in the same cycle.
  - FULL stays FULL with new data: output transfer and input transfer to lane n in the same cycle. The old word is consumed and the new word is loaded.
- `o_ready` is `!o_valid[i_sel] || i_ready[i_sel]`. It is combinational from `i_sel` and `i_ready`; this path is intentional.
- `o_ready` depends only on the selected lane. A full, stalled lane blocks only words addressed to it.
- Lane data registers load only on input transfer to that lane. They hold their value otherwise, including after the lane is drained; the stale value is ignored while `o_valid[n]=0`.
- Words are never dropped or duplicated. Per-lane ordering is preserved.
- `o_accept_cnt` increments by 1 on each input transfer and wraps from 0xFFFF to 0x0000.
- `i_data` and `i_sel` are don't-care while `i_valid=0`.
- The source must hold `i_data` and `i_sel` stable while `i_valid=1` and `o_ready=0`. A change of `i_sel` while stalled is legal; `o_ready` then reflects the new lane.

## Timing
- Reset (asynchronous assert, `i_rst_n=0`):
  - `o_valid=4'b0000`, `o_data=0`, `o_accept_cnt=0`.
  - `o_ready` reads 1 during reset, since all lanes are EMPTY.
- Reset deassertion: the first transfer can occur at the first rising edge after `i_rst_n` rises.
- Reset asserted mid-operation: all buffered words are discarded immediately and the counter is cleared.
- Latency: a word accepted at edge k appears on `o_data` lane `i_sel` with `o_valid[i_sel]=1` after edge k, so it is visible in cycle k+1.
- Throughput:
  - One word per cycle into a lane whose consumer holds `i_ready[n]=1`.
  - One word per cycle overall when alternating lanes, regardless of consumer readiness, until the target lane is FULL.
- Lanes are independent: simultaneous output transfers on any subset of lanes are allowed in one cycle.

## Test plan
- Reset, then send 0xA1 to lane 2 with all `i_ready=0`:
  - `o_valid=4'b0100` one cycle later, lane 2 data = 0xA1.
  - `o_ready=1` for `i_sel=0`, `o_ready=0` for `i_sel=2`.
  - `o_accept_cnt=1`.
- Lane 1 FULL holding 0x11; drive `i_ready[1]=1` and input 0x22 with `i_sel=1` in the same cycle:
  - `o_ready=1` in that cycle.
  - Next cycle lane 1 = 0x22, `o_valid[1]=1`.
  - 0x11 was consumed exactly once.
- Streaming: 0x00..0x0F sent round-robin to lanes 0-3 with all `i_ready=1` continuously:
  - One transfer every cycle, no stall.
  - Each lane outputs its 4 words in order.
  - `o_accept_cnt=16`.
- Backpressure: lane 3 FULL and stalled; the source alternates 0x30 to lane 3 and 0x40 to lane 0:
  - The lane-3 word stalls with `o_ready=0`.
  - The source then switches to lane 0 and 0x40 is accepted.
  - Releasing `i_ready[3]` drains lane 3, then accepts 0x30.
- Reset mid-stream with lanes 0 and 2 FULL:
  - Asynchronous `i_rst_n` low clears `o_valid` and `o_data` to 0 before the next edge, and `o_accept_cnt` to 0.
  - After release, lanes start EMPTY.
- Counter wrap: 65537 accepted words give `o_accept_cnt=0x0001`.
